// File: rtl/dfu_pkg.sv
// Shared definitions for the DFU bank read sequencer: FSM state encoding,
// output buffer depth and the buffer occupancy type.
package dfu_pkg;

    typedef enum logic [1:0] {
        DFU_IDLE  = 2'd0,
        DFU_READ  = 2'd1,
        DFU_DRAIN = 2'd2,
        DFU_DONE  = 2'd3
    } dfu_rd_state_e;

    // Two entries are enough to absorb the word already in flight from the
    // registered SRAM read when the consumer stalls.
    localparam int DFU_RD_BUF_DEPTH = 2;
    localparam int DFU_RD_CNT_W     = $clog2(DFU_RD_BUF_DEPTH + 1);

    typedef logic [DFU_RD_CNT_W-1:0] dfu_buf_cnt_t;

    localparam dfu_buf_cnt_t DFU_RD_BUF_FULL = dfu_buf_cnt_t'(DFU_RD_BUF_DEPTH);

    // Occupancy after one cycle of push/pop activity.
    function automatic dfu_buf_cnt_t dfu_cnt_after(input dfu_buf_cnt_t cnt,
                                                   input logic         push,
                                                   input logic         pop);
        return cnt + dfu_buf_cnt_t'(push) - dfu_buf_cnt_t'(pop);
    endfunction

endpackage

// File: rtl/dfu_skid_fifo.sv
// Small in-order FIFO between the SRAM read port and the output stream.
// Flush has priority over push and pop; pop on empty and push on full
// (without a simultaneous pop) are ignored.
module dfu_skid_fifo
    import dfu_pkg::*;
#(
    parameter int Es = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [Es-1:0] push_data,
    input  logic          pop,
    output logic [Es-1:0] head,
    output logic          empty,
    output logic          full,
    output dfu_buf_cnt_t  count
);

    localparam int PTR_W = $clog2(DFU_RD_BUF_DEPTH);

    logic [Es-1:0]    mem_reg [DFU_RD_BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    dfu_buf_cnt_t     count_reg;

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != DFU_RD_BUF_FULL) || pop_ok);

    // Per-entry storage: an entry is written only when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < DFU_RD_BUF_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_reg[gi] <= '0;
                end else if (!flush && push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= dfu_cnt_after(count_reg, push_ok, pop_ok);
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign empty = (count_reg == '0);
    assign full  = (count_reg == DFU_RD_BUF_FULL);
    assign count = count_reg;

endmodule

// File: rtl/dfu_bank_rd_seq.sv
// Read sequencer draining one DFU bank SRAM into a valid/ready stream.
// On start, issues `length` registered reads from base_addr, buffers the
// same-cycle read data in a 2-entry FIFO and presents it with backpressure.
// Optional feature: define DFU_RD_STRIDE_EN to add a `stride` input that sets
// the address increment; otherwise the increment is fixed at 1.
module dfu_bank_rd_seq
    import dfu_pkg::*;
#(
    parameter int Es        = 8,
    parameter int sram_addr = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [sram_addr-1:0] base_addr,
    input  logic [sram_addr:0]   length,
`ifdef DFU_RD_STRIDE_EN
    input  logic [sram_addr-1:0] stride,
`endif
    input  logic                 abort,
    output logic                 dfu2ip_sram_rd_en,
    output logic [sram_addr-1:0] dfu2ip_sram_rd_addr,
    input  logic [Es-1:0]        dfu2op_bank_sram_data_out,
    input  logic                 dfu2op_bank_sram_data_out_vld,
    output logic [Es-1:0]        out_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 busy,
    output logic                 done
);

    localparam logic [sram_addr:0] LEN_ONE = {{sram_addr{1'b0}}, 1'b1};

    dfu_rd_state_e        state_reg;
    dfu_rd_state_e        state_next;

    logic                 rd_en_reg;
    logic [sram_addr-1:0] rd_addr_reg;
    logic [sram_addr:0]   issued_reg;
    logic [sram_addr:0]   len_reg;
    logic [sram_addr-1:0] stride_val;

`ifdef DFU_RD_STRIDE_EN
    logic [sram_addr-1:0] stride_reg;
    assign stride_val = stride_reg;
`else
    assign stride_val = {{(sram_addr-1){1'b0}}, 1'b1};
`endif

    logic          fifo_empty;
    logic          fifo_full;
    logic [Es-1:0] fifo_head;
    dfu_buf_cnt_t  fifo_count;
    dfu_buf_cnt_t  count_next;

    logic pop;
    logic push;
    logic abort_hit;
    logic can_issue;

    assign pop       = !fifo_empty && out_rdy;
    assign push      = rd_en_reg && dfu2op_bank_sram_data_out_vld && (!fifo_full || pop);
    assign abort_hit = abort && (state_reg != DFU_IDLE);

    // Occupancy as it will stand after this edge; the next read is only
    // scheduled when that leaves room, because its data lands one cycle later.
    assign count_next = dfu_cnt_after(fifo_count, push, pop);
    assign can_issue  = (state_reg == DFU_READ) && (issued_reg != len_reg) &&
                        (count_next != DFU_RD_BUF_FULL);

    dfu_skid_fifo #(
        .Es (Es)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_hit),
        .push      (push),
        .push_data (dfu2op_bank_sram_data_out),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= DFU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DFU_IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DFU_DONE : DFU_READ;
                end
            end
            DFU_READ: begin
                // The final read is active in this cycle once the issue count reaches length.
                if (issued_reg == len_reg) begin
                    state_next = DFU_DRAIN;
                end
            end
            DFU_DRAIN: begin
                if (count_next == '0) begin
                    state_next = DFU_DONE;
                end
            end
            DFU_DONE: begin
                state_next = DFU_IDLE;
            end
            default: begin
                state_next = DFU_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_next = DFU_IDLE;
        end
    end

    // Registered read port, transfer parameters and issue counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
            issued_reg  <= '0;
            len_reg     <= '0;
`ifdef DFU_RD_STRIDE_EN
            stride_reg  <= '0;
`endif
        end else if (abort_hit) begin
            rd_en_reg <= 1'b0;
        end else if ((state_reg == DFU_IDLE) && start) begin
            // First read goes out in the cycle right after start is sampled.
            len_reg     <= length;
            rd_addr_reg <= base_addr;
            rd_en_reg   <= (length != '0);
            issued_reg  <= (length != '0) ? LEN_ONE : '0;
`ifdef DFU_RD_STRIDE_EN
            stride_reg  <= stride;
`endif
        end else if (can_issue) begin
            rd_en_reg   <= 1'b1;
            rd_addr_reg <= rd_addr_reg + stride_val;
            issued_reg  <= issued_reg + LEN_ONE;
        end else begin
            rd_en_reg <= 1'b0;
        end
    end

    // Stream and status outputs.
    always_comb begin
        busy     = (state_reg != DFU_IDLE);
        done     = (state_reg == DFU_DONE);
        out_vld  = !fifo_empty;
        out_data = fifo_head;
    end

    assign dfu2ip_sram_rd_en   = rd_en_reg;
    assign dfu2ip_sram_rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_dfu_bank_rd_seq.sv
// Self-checking bench for dfu_bank_rd_seq with a behavioural SRAM and a
// scoreboard of expected read addresses and stream words.
module tb_dfu_bank_rd_seq;

    localparam int ES = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_rdy = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
`ifdef DFU_RD_STRIDE_EN
    logic [AW-1:0] stride = '0;
`endif
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [ES-1:0] sram_q;
    logic          sram_vld;
    logic [ES-1:0] out_data;
    logic          out_vld;
    logic          busy;
    logic          done;

    logic [ES-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    // Combinational SRAM model: word i holds i+16.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = ES'(i + 16);
    end
    assign sram_q   = mem[rd_addr];
    assign sram_vld = rd_en;

    dfu_bank_rd_seq #(
        .Es        (ES),
        .sram_addr (AW)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .start                         (start),
        .base_addr                     (base_addr),
        .length                        (length),
`ifdef DFU_RD_STRIDE_EN
        .stride                        (stride),
`endif
        .abort                         (abort),
        .dfu2ip_sram_rd_en             (rd_en),
        .dfu2ip_sram_rd_addr           (rd_addr),
        .dfu2op_bank_sram_data_out     (sram_q),
        .dfu2op_bank_sram_data_out_vld (sram_vld),
        .out_data                      (out_data),
        .out_vld                       (out_vld),
        .out_rdy                       (out_rdy),
        .busy                          (busy),
        .done                          (done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    logic [ES-1:0] exp_data_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int rd_total   = 0;
    int busy_total = 0;
    int done_total = 0;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (rd_en) begin
                rd_total++;
                if (exp_addr_q.size() == 0) check("addr_q_len", exp_addr_q.size(), 1);
                else check("rd_addr", rd_addr, exp_addr_q.pop_front());
            end
            if (out_vld && out_rdy) begin
                if (exp_data_q.size() == 0) check("data_q_len", exp_data_q.size(), 1);
                else check("out_data", out_data, exp_data_q.pop_front());
            end
            if (busy) busy_total++;
            if (done) done_total++;
        end
    end

    // Drives start for one cycle and returns #1 into cycle T+1.
    task automatic start_xfer(input int base, input int len, input int strd);
        int a;
        for (int i = 0; i < len; i++) begin
            a = (base + i * strd) % DEPTH;
            exp_addr_q.push_back(AW'(a));
            exp_data_q.push_back(mem[a]);
        end
        base_addr = AW'(base);
        length    = (AW+1)'(len);
`ifdef DFU_RD_STRIDE_EN
        stride    = AW'(strd);
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("xfer base=%0d len=%0d stride=%0d", base, len, strd);
    endtask

    // Returns the cycle index (relative to the start edge) in which done is seen.
    task automatic wait_done(input int first_cyc, output int lat);
        int cyc;
        cyc = first_cyc;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        lat = cyc;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, b0, d0, n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Basic 4-word transfer at full throughput.
        r0 = rd_total;
        start_xfer(3, 4, 1);
        for (int k = 1; k <= 4; k++) begin
            check("t1_rd_en", rd_en, 1);
            if (k == 1) check("t1_vld_c1", out_vld, 0);
            if (k == 2) check("t1_vld_c2", out_vld, 1);
            @(posedge clk); #1;
        end
        wait_done(5, lat);
        check("t1_done_lat", lat, 6);
        check("t1_rd_cnt", rd_total - r0, 4);
        check("t1_sb_left", exp_data_q.size(), 0);

        // Address wrap past the top of the bank.
        start_xfer(14, 4, 1);
        wait_done(1, lat);
        check("t2_done_lat", lat, 6);
        check("t2_sb_left", exp_data_q.size() + exp_addr_q.size(), 0);

        // Backpressure: consumer stalls 5 cycles from the first valid word.
        out_rdy = 1'b0;
        r0 = rd_total;
        start_xfer(2, 6, 1);
        n = 0;
        while (out_vld !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t3_first_vld", out_vld, 1);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_vld", out_vld, 1);
            check("t3_hold_data", out_data, exp_data_q[0]);
            @(posedge clk); #1;
        end
        check("t3_stall_rd_cnt", rd_total - r0, 2);
        out_rdy = 1'b1;
        wait_done(1, lat);
        check("t3_done_seen", lat < 200, 1);
        check("t3_rd_cnt", rd_total - r0, 6);
        check("t3_sb_left", exp_data_q.size(), 0);

        // Zero-length transfer.
        r0 = rd_total; b0 = busy_total; d0 = done_total;
        start_xfer(5, 0, 1);
        wait_done(1, lat);
        check("t4_done_lat", lat, 1);
        check("t4_rd_cnt", rd_total - r0, 0);
        check("t4_busy_cyc", busy_total - b0, 1);
        check("t4_done_cnt", done_total - d0, 1);

        // Abort in the third cycle of an 8-word transfer.
        d0 = done_total;
        start_xfer(0, 8, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_out_vld", out_vld, 0);
        check("t5_rd_en", rd_en, 0);
        exp_data_q.delete();
        exp_addr_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", done_total - d0, 0);
        start_xfer(5, 3, 1);
        wait_done(1, lat);
        check("t5_restart_lat", lat, 5);
        check("t5_sb_left", exp_data_q.size(), 0);

        // Asynchronous reset in the middle of a transfer.
        start_xfer(0, 8, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("t6_rd_en", rd_en, 0);
        check("t6_rd_addr", rd_addr, 0);
        check("t6_out_data", out_data, 0);
        check("t6_out_vld", out_vld, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        exp_data_q.delete();
        exp_addr_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        start_xfer(9, 2, 1);
        wait_done(1, lat);
        check("t6_after_lat", lat, 4);

`ifdef DFU_RD_STRIDE_EN
        // Strided reads: addresses 1, 4, 7.
        start_xfer(1, 3, 3);
        wait_done(1, lat);
        check("t7_stride_lat", lat, 5);
`endif
        check("final_sb_left", exp_data_q.size() + exp_addr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
